// File: rtl/nf_uart_pkg.sv
// nf_uart shared definitions: register offsets, CR bit indices, FSM states.
// Build option: NF_UART_RX_SYNC_EN adds a two-flop uart_rx synchronizer.
package nf_uart_pkg;

  localparam logic [3:0] NF_UART_CR = 4'h0;
  localparam logic [3:0] NF_UART_TX = 4'h4;
  localparam logic [3:0] NF_UART_RX = 4'h8;
  localparam logic [3:0] NF_UART_DR = 4'hC;

  localparam int CR_TX_REQ   = 0;
  localparam int CR_RX_VALID = 1;
  localparam int CR_TR_EN    = 2;
  localparam int CR_REC_EN   = 3;

  typedef enum logic [1:0] {
    TX_IDLE, TX_START, TX_DATA, TX_STOP
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP
  } rx_state_t;

  // Dividers below 2 would make the half-bit point vanish.
  function automatic logic [15:0] eff_div(
    input logic [15:0] dr
  );
    return (dr < 16'd2) ? 16'd2 : dr;
  endfunction

endpackage

// File: rtl/nf_uart_if.sv
// nf_uart register bus: address, write strobe/data, combinational read data.
// Build option: NF_UART_RX_SYNC_EN (see nf_uart_receiver).
interface nf_uart_if;
  logic [31:0] addr;
  logic        we;
  logic [31:0] wd;
  logic [31:0] rd;

  modport master (output addr, we, wd, input rd);
  modport slave  (input addr, we, wd, output rd);
endinterface

// File: rtl/nf_uart_receiver.sv
// nf_uart 8N1 receiver: mid-bit sampling, one-cycle done strobe on good stop.
// Build option: NF_UART_RX_SYNC_EN puts uart_rx through two flops.
module nf_uart_receiver
  import nf_uart_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,
  input  logic [15:0] i_dr,
  input  logic        i_rec_en,
  input  logic        i_rx,
  output logic [7:0]  o_data,
  output logic        o_done
);

  logic w_rx;
`ifdef NF_UART_RX_SYNC_EN
  logic [1:0] r_sync;
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) r_sync <= 2'b11;
    else        r_sync <= {r_sync[0], i_rx};
  end
  assign w_rx = r_sync[1];
`else
  assign w_rx = i_rx;
`endif

  rx_state_t   r_st, w_st_nx;
  logic [15:0] r_cnt, w_cnt_nx;
  logic [2:0]  r_bit, w_bit_nx;
  logic [7:0]  r_sh, w_sh_nx;
  logic [15:0] w_dr;
  logic        w_tick;

  assign w_dr   = eff_div(i_dr);
  assign w_tick = (r_cnt == 16'd0);
  assign o_data = r_sh;

  always_comb begin
    w_st_nx  = r_st;
    w_cnt_nx = r_cnt;
    w_bit_nx = r_bit;
    w_sh_nx  = r_sh;
    o_done   = 1'b0;
    if (r_st != RX_IDLE && !w_tick)
      w_cnt_nx = r_cnt - 16'd1;
    case (r_st)
      RX_IDLE: if (i_rec_en && !w_rx) begin
        w_st_nx  = RX_START;
        w_cnt_nx = (w_dr >> 1) - 16'd1;
      end
      RX_START: if (w_tick) begin
        // a start bit gone high by its midpoint is a glitch
        w_st_nx  = w_rx ? RX_IDLE : RX_DATA;
        w_cnt_nx = w_dr - 16'd1;
        w_bit_nx = 3'd0;
      end
      RX_DATA: if (w_tick) begin
        w_sh_nx  = {w_rx, r_sh[7:1]};
        w_cnt_nx = w_dr - 16'd1;
        w_bit_nx = r_bit + 3'd1;
        if (r_bit == 3'd7) w_st_nx = RX_STOP;
      end
      RX_STOP: if (w_tick) begin
        w_st_nx = RX_IDLE;
        o_done  = w_rx;
      end
      default: w_st_nx = RX_IDLE;
    endcase
    if (r_st != RX_IDLE && !i_rec_en)
      w_st_nx = RX_IDLE;
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_st  <= RX_IDLE;
      r_cnt <= '0;
      r_bit <= '0;
      r_sh  <= '0;
    end else begin
      r_st  <= w_st_nx;
      r_cnt <= w_cnt_nx;
      r_bit <= w_bit_nx;
      r_sh  <= w_sh_nx;
    end
  end

endmodule

// File: rtl/nf_uart.sv
// nf_uart top: register file, inline 8N1 transmitter, receiver instance.
// Build option: NF_UART_RX_SYNC_EN enables the uart_rx synchronizer.
module nf_uart
  import nf_uart_pkg::*;
(
  input  logic     clk,
  input  logic     resetn,
  nf_uart_if.slave bus,
  output logic     uart_tx,
  input  logic     uart_rx
);

  logic [3:0]  r_cr;
  logic [7:0]  r_tx;
  logic [7:0]  r_rx;
  logic [15:0] r_dr;

  logic [1:0] w_sel;
  logic       w_wr_cr, w_wr_tx, w_wr_dr;
  logic       w_tx_clr, w_rx_done;
  logic [7:0] w_rx_data;
  logic       w_unused;

  assign w_sel    = bus.addr[3:2];
  assign w_wr_cr  = bus.we && (w_sel == NF_UART_CR[3:2]);
  assign w_wr_tx  = bus.we && (w_sel == NF_UART_TX[3:2]);
  assign w_wr_dr  = bus.we && (w_sel == NF_UART_DR[3:2]);
  assign w_unused = ^{bus.addr[31:4], bus.addr[1:0], bus.wd[31:16]};

  always_comb begin
    bus.rd = '0;
    case (w_sel)
      NF_UART_CR[3:2]: bus.rd[3:0]  = r_cr;
      NF_UART_TX[3:2]: bus.rd[7:0]  = r_tx;
      NF_UART_RX[3:2]: bus.rd[7:0]  = r_rx;
      default:         bus.rd[15:0] = r_dr;
    endcase
  end

  // hardware updates sit after the software write so they win per bit
  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_cr <= '0;
      r_tx <= '0;
      r_rx <= '0;
      r_dr <= '0;
    end else begin
      if (w_wr_cr) r_cr <= bus.wd[3:0];
      if (w_wr_tx) r_tx <= bus.wd[7:0];
      if (w_wr_dr) r_dr <= bus.wd[15:0];
      if (w_tx_clr) r_cr[CR_TX_REQ] <= 1'b0;
      if (w_rx_done) begin
        r_cr[CR_RX_VALID] <= 1'b1;
        r_cr[CR_REC_EN]   <= 1'b0;
        r_rx              <= w_rx_data;
      end
    end
  end

  tx_state_t   r_tx_st, w_tx_st_nx;
  logic [15:0] r_tx_cnt, w_tx_cnt_nx;
  logic [2:0]  r_tx_bit, w_tx_bit_nx;
  logic [7:0]  r_tx_sh, w_tx_sh_nx;
  logic [15:0] w_dr;
  logic        w_tx_tick;

  assign w_dr      = eff_div(r_dr);
  assign w_tx_tick = (r_tx_cnt == 16'd0);

  always_comb begin
    w_tx_st_nx  = r_tx_st;
    w_tx_cnt_nx = r_tx_cnt;
    w_tx_bit_nx = r_tx_bit;
    w_tx_sh_nx  = r_tx_sh;
    w_tx_clr    = 1'b0;
    if (r_tx_st != TX_IDLE && !w_tx_tick)
      w_tx_cnt_nx = r_tx_cnt - 16'd1;
    case (r_tx_st)
      TX_IDLE: if (r_cr[CR_TR_EN] && r_cr[CR_TX_REQ]) begin
        w_tx_st_nx  = TX_START;
        w_tx_cnt_nx = w_dr - 16'd1;
        w_tx_sh_nx  = r_tx;
      end
      TX_START: if (w_tx_tick) begin
        w_tx_st_nx  = TX_DATA;
        w_tx_cnt_nx = w_dr - 16'd1;
        w_tx_bit_nx = 3'd0;
      end
      TX_DATA: if (w_tx_tick) begin
        w_tx_cnt_nx = w_dr - 16'd1;
        w_tx_sh_nx  = r_tx_sh >> 1;
        w_tx_bit_nx = r_tx_bit + 3'd1;
        if (r_tx_bit == 3'd7) w_tx_st_nx = TX_STOP;
      end
      TX_STOP: if (w_tx_tick) begin
        w_tx_st_nx = TX_IDLE;
        w_tx_clr   = 1'b1;
      end
      default: w_tx_st_nx = TX_IDLE;
    endcase
    if (r_tx_st != TX_IDLE && !r_cr[CR_TR_EN]) begin
      w_tx_st_nx = TX_IDLE;
      w_tx_clr   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge resetn) begin
    if (resetn) begin
      r_tx_st  <= TX_IDLE;
      r_tx_cnt <= '0;
      r_tx_bit <= '0;
      r_tx_sh  <= '0;
    end else begin
      r_tx_st  <= w_tx_st_nx;
      r_tx_cnt <= w_tx_cnt_nx;
      r_tx_bit <= w_tx_bit_nx;
      r_tx_sh  <= w_tx_sh_nx;
    end
  end

  always_comb begin
    case (r_tx_st)
      TX_START: uart_tx = 1'b0;
      TX_DATA:  uart_tx = r_tx_sh[0];
      default:  uart_tx = 1'b1;
    endcase
  end

  nf_uart_receiver u_rx (
    .clk      (clk),
    .resetn   (resetn),
    .i_dr     (r_dr),
    .i_rec_en (r_cr[CR_REC_EN]),
    .i_rx     (uart_rx),
    .o_data   (w_rx_data),
    .o_done   (w_rx_done)
  );

endmodule

// File: tb/tb_nf_uart.sv
// nf_uart bench: register access, TX/RX frames against an 8N1 line model.
// Works with or without NF_UART_RX_SYNC_EN.
module tb_nf_uart;
  import nf_uart_pkg::*;

  logic clk = 1'b0;
  logic resetn;
  logic uart_tx;
  logic uart_rx;
  int   n_vec = 0;
  int   n_err = 0;
  logic [7:0] last_rx = 8'h00;
  string msg = "Hello World!";

  nf_uart_if bus ();

  nf_uart dut (
    .clk     (clk),
    .resetn  (resetn),
    .bus     (bus),
    .uart_tx (uart_tx),
    .uart_rx (uart_rx)
  );

  always #10 clk = ~clk;

  // Line level of 8N1 bit slot k (0 = start, 1..8 = data LSB first, 9 = stop).
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[3'(k - 1)];
    return 1'b1;
  endfunction

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    bus.addr = a;
    bus.we   = 1'b1;
    bus.wd   = d;
    @(posedge clk); #1;
    bus.we   = 1'b0;
  endtask

  task automatic rdr(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rd;
  endtask

  task automatic tx_check(input logic [7:0] b, input int dr, input string tag);
    int eff;
    int bad;
    logic [31:0] v;
    eff = (dr < 2) ? 2 : dr;
    wr(32'(NF_UART_DR), 32'(dr));
    wr(32'(NF_UART_TX), 32'(b));
    wr(32'(NF_UART_CR), 32'h5);
    bad = 0;
    @(posedge clk);
    for (int k = 0; k < 10 * eff; k++) begin
      @(negedge clk);
      if (uart_tx !== frame_bit(b, k / eff)) bad++;
    end
    n_vec++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL %s frame 0x%02h: %0d bad cycles, want 0", tag, b, bad);
    end
    @(posedge clk); #1;
    rdr(32'(NF_UART_CR), v);
    n_vec++;
    if (v !== 32'h4) begin
      n_err++;
      $display("FAIL %s cr_done: got %h want 4", tag, v);
    end
  endtask

  task automatic rx_drive(input logic [7:0] b, input int dr, input logic stop);
    @(posedge clk); #1;
    for (int k = 0; k < 10; k++) begin
      uart_rx = (k == 9) ? stop : frame_bit(b, k);
      repeat (dr) @(posedge clk);
      #1;
    end
    uart_rx = 1'b1;
    repeat (dr + 8) @(posedge clk);
    #1;
  endtask

  task automatic rx_check(input logic [7:0] b, input int dr, input string tag);
    logic [31:0] v;
    wr(32'(NF_UART_DR), 32'(dr));
    wr(32'(NF_UART_CR), 32'h8);
    rx_drive(b, dr, 1'b1);
    last_rx = b;
    rdr(32'(NF_UART_CR), v);
    n_vec++;
    if (v !== 32'h2) begin
      n_err++;
      $display("FAIL %s rx_cr: got %h want 2", tag, v);
    end
    rdr(32'(NF_UART_RX), v);
    n_vec++;
    if (v !== 32'(b)) begin
      n_err++;
      $display("FAIL %s rx_data: got %h want %h", tag, v, b);
    end
  endtask

  task automatic test_reset();
    logic [31:0] v;
    resetn  = 1'b1;
    uart_rx = 1'b1;
    bus.addr = '0;
    bus.we   = 1'b0;
    bus.wd   = '0;
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rdr(32'(i * 4), v);
      n_vec++;
      if (v !== 32'h0) begin
        n_err++;
        $display("FAIL reset_reg%0d: got %h want 0", i, v);
      end
    end
    n_vec++;
    if (uart_tx !== 1'b1) begin
      n_err++;
      $display("FAIL reset_tx: got %b want 1", uart_tx);
    end
  endtask

  task automatic test_dr();
    logic [31:0] v;
    wr(32'(NF_UART_DR), 32'd434);
    rdr(32'(NF_UART_DR), v);
    n_vec++;
    if (v !== 32'h1B2) begin
      n_err++;
      $display("FAIL dr_readback: got %h want 1b2", v);
    end
  endtask

  task automatic test_tx_single();
    tx_check(8'h48, 434, "tx_single");
  endtask

  task automatic test_tx_abort();
    logic [31:0] v;
    wr(32'(NF_UART_DR), 32'd20);
    wr(32'(NF_UART_TX), 32'h00);
    wr(32'(NF_UART_CR), 32'h5);
    repeat (50) @(posedge clk);
    #1;
    n_vec++;
    if (uart_tx !== 1'b0) begin
      n_err++;
      $display("FAIL abort_pre: got %b want 0", uart_tx);
    end
    wr(32'(NF_UART_CR), 32'h1);
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (uart_tx !== 1'b1) begin
      n_err++;
      $display("FAIL abort_line: got %b want 1", uart_tx);
    end
    rdr(32'(NF_UART_CR), v);
    n_vec++;
    if (v !== 32'h0) begin
      n_err++;
      $display("FAIL abort_cr: got %h want 0", v);
    end
  endtask

  // Short divider keeps the twelve-byte runs brief.
  task automatic test_tx_message();
    for (int i = 0; i < msg.len(); i++)
      tx_check(msg[i], 16, "tx_msg");
  endtask

  task automatic test_tx_random();
    tx_check(8'hA5, 0, "tx_dr0");
    tx_check(8'h3C, 1, "tx_dr1");
    for (int i = 0; i < 6; i++)
      tx_check(8'($urandom_range(0, 255)), $urandom_range(0, 40), "tx_rand");
  endtask

  task automatic test_rx_single();
    logic [31:0] v;
    rx_check(8'h65, 434, "rx_single");
    wr(32'(NF_UART_CR), 32'h8);
    rdr(32'(NF_UART_CR), v);
    n_vec++;
    if (v !== 32'h8) begin
      n_err++;
      $display("FAIL rx_clear: got %h want 8", v);
    end
  endtask

  task automatic test_rx_message();
    for (int i = 0; i < msg.len(); i++)
      rx_check(msg[i], 16, "rx_msg");
    for (int i = 0; i < 6; i++)
      rx_check(8'($urandom_range(0, 255)), $urandom_range(4, 40), "rx_rand");
  endtask

  task automatic test_rx_disabled();
    logic [31:0] v;
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    wr(32'(NF_UART_CR), 32'h0);
    rx_drive(b, 20, 1'b1);
    rdr(32'(NF_UART_CR), v);
    n_vec++;
    if (v !== 32'h0) begin
      n_err++;
      $display("FAIL rx_off_cr: got %h want 0", v);
    end
    rdr(32'(NF_UART_RX), v);
    n_vec++;
    if (v !== 32'(last_rx)) begin
      n_err++;
      $display("FAIL rx_off_data: got %h want %h", v, last_rx);
    end
  endtask

  task automatic test_rx_framing();
    logic [31:0] v;
    wr(32'(NF_UART_DR), 32'd40);
    wr(32'(NF_UART_CR), 32'h8);
    rx_drive(~last_rx, 40, 1'b0);
    rdr(32'(NF_UART_CR), v);
    n_vec++;
    if (v !== 32'h8) begin
      n_err++;
      $display("FAIL frame_err_cr: got %h want 8", v);
    end
    rdr(32'(NF_UART_RX), v);
    n_vec++;
    if (v !== 32'(last_rx)) begin
      n_err++;
      $display("FAIL frame_err_data: got %h want %h", v, last_rx);
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] v;
    wr(32'(NF_UART_DR), 32'd434);
    wr(32'(NF_UART_TX), 32'h00);
    wr(32'(NF_UART_CR), 32'h5);
    repeat (1000) @(posedge clk);
    #5 resetn = 1'b1;
    #1;
    n_vec++;
    if (uart_tx !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_tx: got %b want 1", uart_tx);
    end
    rdr(32'(NF_UART_CR), v);
    n_vec++;
    if (v !== 32'h0) begin
      n_err++;
      $display("FAIL rst_mid_cr: got %h want 0", v);
    end
    @(posedge clk); #1 resetn = 1'b0;
    last_rx = 8'h00;
  endtask

  initial begin
    test_reset();
    test_dr();
    test_tx_single();
    test_tx_abort();
    test_tx_message();
    test_tx_random();
    test_rx_single();
    test_rx_message();
    test_rx_disabled();
    test_rx_framing();
    test_reset_midframe();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
